controller: RTL and testbench
=============================

# controller

Multi-cycle control unit for the 8-bit accumulator CPU. It sits directly downstream of the datapath's status outputs (opcode, DI, CZN flags) and upstream of every datapath control input. A Moore FSM sequences the fetch, decode, memory, ALU and write-back cycles, driving the 18 datapath control lines.

## Interface
- No parameters; encodings are fixed below.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- IrToCU  in  4  IR[7:4] opcode
- DiToCU  in  5  latched IR[4:0]; reserved, no effect on sequencing
- CznToCU  in  3  flags: [0]=C, [1]=Z, [2]=N
- pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, aRegWriteEn, bRegWriteEn, aluResWriteEn, accumulatorWriteEn, memoryWriteEn, ldCZN  out  1 each  datapath enables
- PcOrTR  out  1  memory address: 1=PC, 0=TR
- regOrMem  out  1  B-reg source: 0=memory, 1=accumulator
- RegBOr0, RegAOr0  out  1 each  1 forces that ALU operand to 0
- accAddressSel  out  2  00=DI[4:3], 01=IR[1:0], 10=IR[3:2]
- aluOpControl  out  2  00 ADD (B+A), 01 SUB (A−B), 10 AND, 11 NOT
- instrDone  out  1  high in the final state of each instruction

## Operation
- ISA, op3=IR[7:5]: 000 LDA, 001 STA, 010 ADDM, 011 SUBM, 100 JMP, 101 JZ, 110 JC.
  - These are 2-byte instructions: address = {IR[4:0], byte2}; register = DI[4:3].
- IR[7:4]=1110 ADDR: r[IR[3:2]] ← r[IR[3:2]] + r[IR[1:0]].
- IR[7:4]=1111 MOVR: r[IR[3:2]] ← r[IR[1:0]].
- Each state lists only its asserted outputs; every unlisted output is 0. Mux selects default to 0.
- FETCH: PcOrTR, irWriteEn, pcInc → DECODE.
- DECODE: diLoadEn → R_LDB if op3=111, else FETCH2.
- FETCH2: PcOrTR, trWriteEn, pcInc → MEM_RD (LDA/ADDM/SUBM), ST_LD (STA), JUMP (branches).
- MEM_RD: bRegWriteEn (regOrMem=0, address=TR), aRegWriteEn (sel 00) → M_EXEC.
- M_EXEC: aluResWriteEn, ldCZN.
  - LDA: RegAOr0=1, op 00.
  - ADDM: op 00.
  - SUBM: op 01.
  - Next state → M_WB.
- M_WB: accumulatorWriteEn (sel 00), instrDone → FETCH.
- ST_LD: regOrMem=1, sel 00, bRegWriteEn → ST_ALU.
- ST_ALU: RegAOr0=1, op 00, aluResWriteEn; ldCZN=0 → ST_WR.
- ST_WR: PcOrTR=0, memoryWriteEn, instrDone → FETCH.
- JUMP: pcLoadEn=taken, instrDone → FETCH.
  - JMP: taken=1.
  - JZ: taken=Z.
  - JC: taken=C.
- R_LDB: regOrMem=1, sel 01, bRegWriteEn → R_LDA.
- R_LDA: sel 10, aRegWriteEn → R_EXEC.
- R_EXEC: aluResWriteEn, op 00.
  - ADDR: ldCZN=1.
  - MOVR: RegAOr0=1, ldCZN=0.
  - Next state → R_WB.
- R_WB: sel 10, accumulatorWriteEn, instrDone → FETCH.
- Branch conditions sample CznToCU combinationally in JUMP. Flags reflect the last instruction that asserted ldCZN.

## Timing
- State encoding: 4-bit register, 14 states. State updates on the rising clk edge.
- Outputs are combinational from the state register and IrToCU/CznToCU only; there are no combinational paths from other inputs.
- Reset: rst low forces state=FETCH immediately. Every output is held at 0 while rst is low.
  - The first FETCH outputs appear in the same cycle that rst deasserts.
- Reset mid-instruction aborts it with no further enables. A half-finished STA never asserts memoryWriteEn.
- Latency: LDA/ADDM/SUBM/STA = 6 cycles; ADDR/MOVR = 6 cycles; JMP/JZ/JC = 4 cycles, taken or not.
- instrDone is high for exactly one cycle per instruction. The next FETCH follows on the next cycle.
- The datapath memory read is combinational: MEM_RD and FETCH capture the data in the same cycle.
- pcInc and pcLoadEn are never asserted in the same cycle.

## Configuration
- CU_COND_BRANCH_EN defined: JZ/JC branch on Z/C as above.
- CU_COND_BRANCH_EN undefined: JZ/JC still take FETCH2 and JUMP (4 cycles, PC advanced by 2). pcLoadEn is forced to 0, so they act as 2-byte NOPs. JMP is unaffected.

## Test plan
- Reset: hold rst=0 for 3 cycles → all outputs 0; release → irWriteEn=1, pcInc=1, PcOrTR=1 in the first cycle.
- LDA, IR=8'h05 → sequence FETCH, DECODE, FETCH2, MEM_RD, M_EXEC, M_WB.
  - M_EXEC: RegAOr0=1, aluOpControl=00, ldCZN=1.
  - M_WB: accumulatorWriteEn=1, accAddressSel=00, instrDone=1.
- STA, IR=8'h20 → ST_WR asserts memoryWriteEn=1 and PcOrTR=0; ldCZN stays 0 for all 6 cycles.
- JZ, IR=8'hA0:
  - CznToCU=3'b010 → pcLoadEn=1 in cycle 4.
  - CznToCU=3'b000 → pcLoadEn=0.
  - With CU_COND_BRANCH_EN undefined and Z=1 → pcLoadEn=0.
- ADDR, IR=8'hE6 → R_LDB sel=01, R_LDA sel=10, R_EXEC op=00 with ldCZN=1, R_WB writes with sel=10.
  - MOVR, IR=8'hF6 → R_EXEC with RegAOr0=1 and ldCZN=0.
- Pull rst low during ST_ALU → memoryWriteEn never asserts; after release, execution restarts at FETCH.

Source files
------------

// File: rtl/controller_if.sv
// Status/control bundle between the accumulator CPU datapath and its controller.
// The datapath side uses the master modport; the controller uses the slave modport.
interface controller_if;
   logic [3:0] IrToCU;
   logic [4:0] DiToCU;
   logic [2:0] CznToCU;
   logic       pcInc;
   logic       pcLoadEn;
   logic       diLoadEn;
   logic       irWriteEn;
   logic       trWriteEn;
   logic       aRegWriteEn;
   logic       bRegWriteEn;
   logic       aluResWriteEn;
   logic       accumulatorWriteEn;
   logic       memoryWriteEn;
   logic       ldCZN;
   logic       PcOrTR;
   logic       regOrMem;
   logic       RegBOr0;
   logic       RegAOr0;
   logic [1:0] accAddressSel;
   logic [1:0] aluOpControl;
   logic       instrDone;

   modport master (
      output IrToCU, DiToCU, CznToCU,
      input  pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, aRegWriteEn,
             bRegWriteEn, aluResWriteEn, accumulatorWriteEn, memoryWriteEn,
             ldCZN, PcOrTR, regOrMem, RegBOr0, RegAOr0, accAddressSel,
             aluOpControl, instrDone
   );

   modport slave (
      input  IrToCU, DiToCU, CznToCU,
      output pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, aRegWriteEn,
             bRegWriteEn, aluResWriteEn, accumulatorWriteEn, memoryWriteEn,
             ldCZN, PcOrTR, regOrMem, RegBOr0, RegAOr0, accAddressSel,
             aluOpControl, instrDone
   );
endinterface

// File: rtl/controller.sv
// Multi-cycle Moore control unit for the 8-bit accumulator CPU.
// Optional feature: define CU_COND_BRANCH_EN to make JZ/JC branch on Z/C;
// otherwise JZ/JC behave as 2-byte NOPs (JMP always loads the PC).
module controller (
   input  logic        clk,
   input  logic        rst,
   controller_if.slave bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_FETCH2 = 4'd2,
      S_MEM_RD = 4'd3,
      S_M_EXEC = 4'd4,
      S_M_WB   = 4'd5,
      S_ST_LD  = 4'd6,
      S_ST_ALU = 4'd7,
      S_ST_WR  = 4'd8,
      S_JUMP   = 4'd9,
      S_R_LDB  = 4'd10,
      S_R_LDA  = 4'd11,
      S_R_EXEC = 4'd12,
      S_R_WB   = 4'd13
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [2:0] op3;
   logic       is_movr;
   logic       branch_taken;
   logic [7:0] unused_status;

   assign op3     = bus.IrToCU[3:1];
   assign is_movr = bus.IrToCU[0];

   // DI is latched for the datapath only; N never steers a branch.
   assign unused_status = {bus.DiToCU, bus.CznToCU};

`ifdef CU_COND_BRANCH_EN
   // Branch decision from the live flags while sitting in JUMP.
   always_comb begin
      branch_taken = 1'b0;
      case (op3)
         3'b100:  branch_taken = 1'b1;
         3'b101:  branch_taken = bus.CznToCU[1];
         3'b110:  branch_taken = bus.CznToCU[0];
         default: branch_taken = 1'b0;
      endcase
   end
`else
   // Only the unconditional jump reloads the PC.
   always_comb begin
      branch_taken = 1'b0;
      if (op3 == 3'b100) begin
         branch_taken = 1'b1;
      end
   end
`endif

   // Next-state sequencing through fetch, decode, memory, ALU and write-back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = (op3 == 3'b111) ? S_R_LDB : S_FETCH2;
         S_FETCH2: begin
            case (op3)
               3'b000, 3'b010, 3'b011: state_d = S_MEM_RD;
               3'b001:                 state_d = S_ST_LD;
               3'b100, 3'b101, 3'b110: state_d = S_JUMP;
               default:                state_d = S_FETCH;
            endcase
         end
         S_MEM_RD: state_d = S_M_EXEC;
         S_M_EXEC: state_d = S_M_WB;
         S_M_WB:   state_d = S_FETCH;
         S_ST_LD:  state_d = S_ST_ALU;
         S_ST_ALU: state_d = S_ST_WR;
         S_ST_WR:  state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_R_LDB:  state_d = S_R_LDA;
         S_R_LDA:  state_d = S_R_EXEC;
         S_R_EXEC: state_d = S_R_WB;
         S_R_WB:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // State register; reset parks the machine in FETCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore control decode; every line is forced low while reset is held.
   always_comb begin
      bus.pcInc              = 1'b0;
      bus.pcLoadEn           = 1'b0;
      bus.diLoadEn           = 1'b0;
      bus.irWriteEn          = 1'b0;
      bus.trWriteEn          = 1'b0;
      bus.aRegWriteEn        = 1'b0;
      bus.bRegWriteEn        = 1'b0;
      bus.aluResWriteEn      = 1'b0;
      bus.accumulatorWriteEn = 1'b0;
      bus.memoryWriteEn      = 1'b0;
      bus.ldCZN              = 1'b0;
      bus.PcOrTR             = 1'b0;
      bus.regOrMem           = 1'b0;
      bus.RegBOr0            = 1'b0;
      bus.RegAOr0            = 1'b0;
      bus.accAddressSel      = '0;
      bus.aluOpControl       = '0;
      bus.instrDone          = 1'b0;
      if (rst) begin
         case (state_q)
            S_FETCH: begin
               bus.PcOrTR    = 1'b1;
               bus.irWriteEn = 1'b1;
               bus.pcInc     = 1'b1;
            end
            S_DECODE: bus.diLoadEn = 1'b1;
            S_FETCH2: begin
               bus.PcOrTR    = 1'b1;
               bus.trWriteEn = 1'b1;
               bus.pcInc     = 1'b1;
            end
            S_MEM_RD: begin
               bus.bRegWriteEn = 1'b1;
               bus.aRegWriteEn = 1'b1;
            end
            S_M_EXEC: begin
               bus.aluResWriteEn = 1'b1;
               bus.ldCZN         = 1'b1;
               if (op3 == 3'b000) begin
                  bus.RegAOr0 = 1'b1;
               end
               if (op3 == 3'b011) begin
                  bus.aluOpControl = 2'b01;
               end
            end
            S_M_WB: begin
               bus.accumulatorWriteEn = 1'b1;
               bus.instrDone          = 1'b1;
            end
            S_ST_LD: begin
               bus.regOrMem    = 1'b1;
               bus.bRegWriteEn = 1'b1;
            end
            S_ST_ALU: begin
               bus.RegAOr0       = 1'b1;
               bus.aluResWriteEn = 1'b1;
            end
            S_ST_WR: begin
               bus.memoryWriteEn = 1'b1;
               bus.instrDone     = 1'b1;
            end
            S_JUMP: begin
               bus.pcLoadEn  = branch_taken;
               bus.instrDone = 1'b1;
            end
            S_R_LDB: begin
               bus.regOrMem      = 1'b1;
               bus.accAddressSel = 2'b01;
               bus.bRegWriteEn   = 1'b1;
            end
            S_R_LDA: begin
               bus.accAddressSel = 2'b10;
               bus.aRegWriteEn   = 1'b1;
            end
            S_R_EXEC: begin
               bus.aluResWriteEn = 1'b1;
               bus.ldCZN         = ~is_movr;
               bus.RegAOr0       = is_movr;
            end
            S_R_WB: begin
               bus.accAddressSel      = 2'b10;
               bus.accumulatorWriteEn = 1'b1;
               bus.instrDone          = 1'b1;
            end
            default: begin
               bus.instrDone = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controller.sv
// Directed bench for the accumulator CPU controller: steps through each
// instruction class cycle by cycle and compares all control lines at once.
module tb_controller;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   controller_if bus_if ();

   controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control lines packed MSB first in this order.
   logic [19:0] obs;
   assign obs = {bus_if.pcInc, bus_if.pcLoadEn, bus_if.diLoadEn, bus_if.irWriteEn,
                 bus_if.trWriteEn, bus_if.aRegWriteEn, bus_if.bRegWriteEn,
                 bus_if.aluResWriteEn, bus_if.accumulatorWriteEn,
                 bus_if.memoryWriteEn, bus_if.ldCZN, bus_if.PcOrTR,
                 bus_if.regOrMem, bus_if.RegBOr0, bus_if.RegAOr0,
                 bus_if.accAddressSel, bus_if.aluOpControl, bus_if.instrDone};

   localparam logic [19:0] M_PC_INC     = 20'h80000;
   localparam logic [19:0] M_PC_LD      = 20'h40000;
   localparam logic [19:0] M_DI_LD      = 20'h20000;
   localparam logic [19:0] M_IR_WE      = 20'h10000;
   localparam logic [19:0] M_TR_WE      = 20'h08000;
   localparam logic [19:0] M_A_WE       = 20'h04000;
   localparam logic [19:0] M_B_WE       = 20'h02000;
   localparam logic [19:0] M_ALU_WE     = 20'h01000;
   localparam logic [19:0] M_ACC_WE     = 20'h00800;
   localparam logic [19:0] M_MEM_WE     = 20'h00400;
   localparam logic [19:0] M_LD_CZN     = 20'h00200;
   localparam logic [19:0] M_PC_OR_TR   = 20'h00100;
   localparam logic [19:0] M_REG_OR_MEM = 20'h00080;
   localparam logic [19:0] M_A_OR0      = 20'h00020;
   localparam logic [19:0] M_SEL_IR10   = 20'h00008;
   localparam logic [19:0] M_SEL_IR32   = 20'h00010;
   localparam logic [19:0] M_OP_SUB     = 20'h00002;
   localparam logic [19:0] M_DONE       = 20'h00001;

   localparam logic [19:0] E_IDLE     = 20'h00000;
   localparam logic [19:0] E_FETCH    = M_PC_INC | M_IR_WE | M_PC_OR_TR;
   localparam logic [19:0] E_DECODE   = M_DI_LD;
   localparam logic [19:0] E_FETCH2   = M_PC_INC | M_TR_WE | M_PC_OR_TR;
   localparam logic [19:0] E_MEM_RD   = M_B_WE | M_A_WE;
   localparam logic [19:0] E_EX_LDA   = M_ALU_WE | M_LD_CZN | M_A_OR0;
   localparam logic [19:0] E_EX_SUB   = M_ALU_WE | M_LD_CZN | M_OP_SUB;
   localparam logic [19:0] E_M_WB     = M_ACC_WE | M_DONE;
   localparam logic [19:0] E_ST_LD    = M_REG_OR_MEM | M_B_WE;
   localparam logic [19:0] E_ST_ALU   = M_A_OR0 | M_ALU_WE;
   localparam logic [19:0] E_ST_WR    = M_MEM_WE | M_DONE;
   localparam logic [19:0] E_J_TAKEN  = M_PC_LD | M_DONE;
   localparam logic [19:0] E_J_NOT    = M_DONE;
   localparam logic [19:0] E_R_LDB    = M_REG_OR_MEM | M_SEL_IR10 | M_B_WE;
   localparam logic [19:0] E_R_LDA    = M_SEL_IR32 | M_A_WE;
   localparam logic [19:0] E_R_ADD    = M_ALU_WE | M_LD_CZN;
   localparam logic [19:0] E_R_MOV    = M_ALU_WE | M_A_OR0;
   localparam logic [19:0] E_R_WB     = M_SEL_IR32 | M_ACC_WE | M_DONE;
`ifdef CU_COND_BRANCH_EN
   localparam logic [19:0] E_J_COND   = E_J_TAKEN;
`else
   localparam logic [19:0] E_J_COND   = E_J_NOT;
`endif

   task automatic check(input string tag, input logic [19:0] exp);
      #1;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [19:0] exp);
      check(tag, exp);
      tick();
   endtask

   task automatic load(input logic [7:0] ir, input logic [2:0] czn);
      bus_if.IrToCU  = ir[7:4];
      bus_if.DiToCU  = ir[4:0];
      bus_if.CznToCU = czn;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      load(8'h05, 3'b000);
      #2 rst = 1'b0;

      cyc("rst_0", E_IDLE);
      cyc("rst_1", E_IDLE);
      cyc("rst_2", E_IDLE);
      rst = 1'b1;

      // LDA 0x05
      cyc("lda_fetch", E_FETCH);
      cyc("lda_decode", E_DECODE);
      cyc("lda_fetch2", E_FETCH2);
      cyc("lda_memrd", E_MEM_RD);
      cyc("lda_exec", E_EX_LDA);
      cyc("lda_wb", E_M_WB);

      // SUBM 0x60
      load(8'h60, 3'b000);
      cyc("subm_fetch", E_FETCH);
      cyc("subm_decode", E_DECODE);
      cyc("subm_fetch2", E_FETCH2);
      cyc("subm_memrd", E_MEM_RD);
      cyc("subm_exec", E_EX_SUB);
      cyc("subm_wb", E_M_WB);

      // STA 0x20
      load(8'h20, 3'b000);
      cyc("sta_fetch", E_FETCH);
      cyc("sta_decode", E_DECODE);
      cyc("sta_fetch2", E_FETCH2);
      cyc("sta_ld", E_ST_LD);
      cyc("sta_alu", E_ST_ALU);
      cyc("sta_wr", E_ST_WR);

      // JMP 0x80
      load(8'h80, 3'b000);
      cyc("jmp_fetch", E_FETCH);
      cyc("jmp_decode", E_DECODE);
      cyc("jmp_fetch2", E_FETCH2);
      cyc("jmp_jump", E_J_TAKEN);

      // JZ with Z set
      load(8'hA0, 3'b010);
      cyc("jz1_fetch", E_FETCH);
      cyc("jz1_decode", E_DECODE);
      cyc("jz1_fetch2", E_FETCH2);
      cyc("jz1_jump", E_J_COND);

      // JZ with Z clear
      load(8'hA0, 3'b000);
      cyc("jz0_fetch", E_FETCH);
      cyc("jz0_decode", E_DECODE);
      cyc("jz0_fetch2", E_FETCH2);
      cyc("jz0_jump", E_J_NOT);

      // JC with C set
      load(8'hC0, 3'b001);
      cyc("jc1_fetch", E_FETCH);
      cyc("jc1_decode", E_DECODE);
      cyc("jc1_fetch2", E_FETCH2);
      cyc("jc1_jump", E_J_COND);

      // JC with Z and N set but C clear
      load(8'hC0, 3'b110);
      cyc("jc0_fetch", E_FETCH);
      cyc("jc0_decode", E_DECODE);
      cyc("jc0_fetch2", E_FETCH2);
      cyc("jc0_jump", E_J_NOT);

      // ADDR 0xE6
      load(8'hE6, 3'b000);
      cyc("addr_fetch", E_FETCH);
      cyc("addr_decode", E_DECODE);
      cyc("addr_ldb", E_R_LDB);
      cyc("addr_lda", E_R_LDA);
      cyc("addr_exec", E_R_ADD);
      cyc("addr_wb", E_R_WB);

      // MOVR 0xF6
      load(8'hF6, 3'b000);
      cyc("movr_fetch", E_FETCH);
      cyc("movr_decode", E_DECODE);
      cyc("movr_ldb", E_R_LDB);
      cyc("movr_lda", E_R_LDA);
      cyc("movr_exec", E_R_MOV);
      cyc("movr_wb", E_R_WB);

      // STA aborted by reset in ST_ALU
      load(8'h20, 3'b000);
      cyc("abort_fetch", E_FETCH);
      cyc("abort_decode", E_DECODE);
      cyc("abort_fetch2", E_FETCH2);
      cyc("abort_ld", E_ST_LD);
      check("abort_alu", E_ST_ALU);
      rst = 1'b0;
      check("abort_rst", E_IDLE);
      tick();
      cyc("abort_hold", E_IDLE);
      rst = 1'b1;

      // Restart from FETCH with a JMP
      load(8'h80, 3'b000);
      cyc("restart_fetch", E_FETCH);
      cyc("restart_decode", E_DECODE);
      cyc("restart_fetch2", E_FETCH2);
      cyc("restart_jump", E_J_TAKEN);
      cyc("restart_next", E_FETCH);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
